// File: rtl/lcd_status_reader_if.sv
// Request/response handshake between a client and the HD44780 status/data reader.
interface lcd_status_reader_if;
  logic       rd_req;
  logic       rd_rs;
  logic       poll;
  logic       ready;
  logic       done;
  logic       timeout;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;

  modport master (
    output rd_req, rd_rs, poll,
    input  ready, done, timeout, rd_data, busy_flag, addr_cnt
  );

  modport slave (
    input  rd_req, rd_rs, poll,
    output ready, done, timeout, rd_data, busy_flag, addr_cnt
  );
endinterface

// File: rtl/lcd_status_reader.sv
// HD44780 read-cycle engine: status or data reads with optional busy-flag polling.
// Drives E/RS/R_nW while bus_own is high; the shared pads are arbitrated above.
module lcd_status_reader #(
  parameter int T_AS      = 4,
  parameter int T_EH      = 25,
  parameter int T_EL      = 25,
  parameter int MAX_POLLS = 1023
) (
  input  logic                clk,
  input  logic                reset,
  lcd_status_reader_if.slave  rd_bus,
  input  logic [7:0]          lcd_data_in,
  output logic                bus_own,
  output logic                lcd_e,
  output logic                lcd_rs,
  output logic                lcd_rnw
);

  localparam int T_MAX_AE = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int T_MAX    = (T_MAX_AE > T_EL) ? T_MAX_AE : T_EL;
  localparam int TW       = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);
  localparam int CW       = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    E_LOW,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          phase_end;
  logic          rs_q;
  logic          poll_q;
  logic          timeout_q;
  logic [CW-1:0] poll_cnt;
  logic [7:0]    capture;
  logic [7:0]    rd_data_q;
  logic          busy_flag_q;
  logic [6:0]    addr_cnt_q;
  logic          ready_w;
  logic          done_w;
  logic          timeout_w;
  logic          poll_again;

  assign rd_bus.ready     = ready_w;
  assign rd_bus.done      = done_w;
  assign rd_bus.timeout   = timeout_w;
  assign rd_bus.rd_data   = rd_data_q;
  assign rd_bus.busy_flag = busy_flag_q;
  assign rd_bus.addr_cnt  = addr_cnt_q;

  assign poll_again = poll_q && capture[7] && (poll_cnt != CW'(MAX_POLLS));

  always_comb begin
    phase_end = 1'b0;
    case (state)
      SETUP:   phase_end = (timer == TW'(T_AS - 1));
      E_HIGH:  phase_end = (timer == TW'(T_EH - 1));
      E_LOW:   phase_end = (timer == TW'(T_EL - 1));
      default: phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Pin levels are decoded from the state alone, so an async reset drops E at once.
  always_comb begin
    state_next = state;
    ready_w    = 1'b0;
    done_w     = 1'b0;
    timeout_w  = 1'b0;
    bus_own    = 1'b0;
    lcd_e      = 1'b0;
    lcd_rs     = 1'b0;
    lcd_rnw    = 1'b0;
    case (state)
      IDLE: begin
        ready_w = 1'b1;
        if (rd_bus.rd_req) state_next = SETUP;
      end
      SETUP: begin
        bus_own = 1'b1;
        lcd_rs  = rs_q;
        lcd_rnw = 1'b1;
        if (phase_end) state_next = E_HIGH;
      end
      E_HIGH: begin
        bus_own = 1'b1;
        lcd_e   = 1'b1;
        lcd_rs  = rs_q;
        lcd_rnw = 1'b1;
        if (phase_end) state_next = E_LOW;
      end
      E_LOW: begin
        bus_own = 1'b1;
        lcd_rs  = rs_q;
        lcd_rnw = 1'b1;
        if (phase_end) state_next = CHECK;
      end
      CHECK: begin
        bus_own    = 1'b1;
        lcd_rs     = rs_q;
        lcd_rnw    = 1'b1;
        state_next = poll_again ? SETUP : DONE;
      end
      DONE: begin
        done_w     = 1'b1;
        timeout_w  = timeout_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   timer <= '0;
    else if (state_next != state) timer <= '0;
    else if (state == SETUP || state == E_HIGH || state == E_LOW)
      timer <= timer + TW'(1);
  end

  // Capture and poll count advance together on the last E-high cycle of each pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q        <= 1'b0;
      poll_q      <= 1'b0;
      timeout_q   <= 1'b0;
      poll_cnt    <= '0;
      capture     <= 8'h00;
      rd_data_q   <= 8'h00;
      busy_flag_q <= 1'b0;
      addr_cnt_q  <= 7'h00;
    end else begin
      if (state == IDLE && rd_bus.rd_req) begin
        rs_q      <= rd_bus.rd_rs;
        poll_q    <= rd_bus.poll & ~rd_bus.rd_rs;
        poll_cnt  <= '0;
        timeout_q <= 1'b0;
      end
      if (state == E_HIGH && phase_end) begin
        capture  <= lcd_data_in;
        poll_cnt <= poll_cnt + CW'(1);
      end
      if (state == CHECK && !poll_again) begin
        timeout_q <= poll_q && capture[7];
        rd_data_q <= capture;
        if (!rs_q) begin
          busy_flag_q <= capture[7];
          addr_cnt_q  <= capture[6:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader with MAX_POLLS shortened to 4.
module tb_lcd_status_reader;

  logic       clk;
  logic       reset;
  logic [7:0] lcd_data_in;
  logic       bus_own;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rnw;

  int vectors;
  int miscompares;

  int   done_cyc;
  int   done_count;
  int   pulses;
  int   e_first;
  int   e_last;
  int   rnw_first;
  int   rs_bad;
  int   stable_bad;
  logic timeout_at_done;
  logic [7:0] data_at_done;
  logic post_rnw;
  logic post_ready;
  logic ready_at_start;

  lcd_status_reader_if rd_bus ();

  lcd_status_reader #(
    .T_AS      (4),
    .T_EH      (25),
    .T_EL      (25),
    .MAX_POLLS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_bus      (rd_bus.slave),
    .lcd_data_in (lcd_data_in),
    .bus_own     (bus_own),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rnw     (lcd_rnw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Cycle 0 is the negedge where rd_req is raised; every later negedge is the next cycle.
  task automatic apply_stimulus(input logic rs, input logic poll_in, input logic [7:0] first_byte,
                                input logic [7:0] later_byte, input int n_first,
                                input int retrig_cyc, input int tail);
    logic prev_e;
    logic prev_rs;
    logic prev_rnw;
    done_cyc        = -1;
    done_count      = 0;
    pulses          = 0;
    e_first         = -1;
    e_last          = -1;
    rnw_first       = -1;
    rs_bad          = 0;
    stable_bad      = 0;
    timeout_at_done = 1'bx;
    data_at_done    = 8'hxx;
    post_rnw        = 1'bx;
    post_ready      = 1'bx;
    ready_at_start  = rd_bus.ready;
    rd_bus.rd_rs    = rs;
    rd_bus.poll     = poll_in;
    rd_bus.rd_req   = 1'b1;
    lcd_data_in     = (n_first > 0) ? first_byte : later_byte;
    prev_e          = lcd_e;
    prev_rs         = lcd_rs;
    prev_rnw        = lcd_rnw;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      rd_bus.rd_req = (cyc == retrig_cyc);
      if (lcd_e && !prev_e) begin
        pulses++;
        if (e_first < 0) e_first = cyc;
        lcd_data_in = (pulses <= n_first) ? first_byte : later_byte;
      end
      if (lcd_e) e_last = cyc;
      if (lcd_rnw && rnw_first < 0) rnw_first = cyc;
      if (bus_own && lcd_rs !== rs) rs_bad++;
      if (lcd_e && (!bus_own || (prev_e && (lcd_rs !== prev_rs || lcd_rnw !== prev_rnw)))) stable_bad++;
      if (rd_bus.timeout && !rd_bus.done) stable_bad++;
      if (rd_bus.done) begin
        done_count++;
        if (done_cyc < 0) begin
          done_cyc        = cyc;
          timeout_at_done = rd_bus.timeout;
          data_at_done    = rd_bus.rd_data;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        post_rnw   = lcd_rnw;
        post_ready = rd_bus.ready;
      end
      prev_e   = lcd_e;
      prev_rs  = lcd_rs;
      prev_rnw = lcd_rnw;
      if (done_cyc >= 0 && cyc >= done_cyc + tail) break;
    end
    rd_bus.rd_req = 1'b0;
  endtask

  initial begin
    int idle_changes;
    int done_seen;
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b0;
    rd_bus.rd_req = 1'b0;
    rd_bus.rd_rs  = 1'b0;
    rd_bus.poll   = 1'b0;
    lcd_data_in   = 8'h00;

    repeat (3) @(negedge clk);
    check_output("reset_lcd_e",   32'(lcd_e),            32'h0);
    check_output("reset_lcd_rnw", 32'(lcd_rnw),          32'h0);
    check_output("reset_lcd_rs",  32'(lcd_rs),           32'h0);
    check_output("reset_bus_own", 32'(bus_own),          32'h0);
    check_output("reset_ready",   32'(rd_bus.ready),     32'h1);
    check_output("reset_done",    32'(rd_bus.done),      32'h0);
    check_output("reset_rd_data", 32'(rd_bus.rd_data),   32'h00);
    check_output("reset_bf",      32'(rd_bus.busy_flag), 32'h0);
    check_output("reset_ac",      32'(rd_bus.addr_cnt),  32'h00);

    reset = 1'b1;
    idle_changes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({lcd_e, lcd_rs, lcd_rnw, bus_own, rd_bus.ready, rd_bus.done, rd_bus.timeout,
           rd_bus.rd_data, rd_bus.busy_flag, rd_bus.addr_cnt} !== {7'b0000100, 8'h00, 1'b0, 7'h00})
        idle_changes++;
    end
    check_output("idle_quiet", 32'(idle_changes), 32'd0);

    $display("[TB] single status read");
    apply_stimulus(1'b0, 1'b0, 8'h2A, 8'h2A, 1, -1, 2);
    check_output("st_ready_start", 32'(ready_at_start),  32'h1);
    check_output("st_rnw_first",   32'(rnw_first),       32'd1);
    check_output("st_e_first",     32'(e_first),         32'd5);
    check_output("st_e_last",      32'(e_last),          32'd29);
    check_output("st_pulses",      32'(pulses),          32'd1);
    check_output("st_done_cyc",    32'(done_cyc),        32'd56);
    check_output("st_timeout",     32'(timeout_at_done), 32'h0);
    check_output("st_rd_data",     32'(data_at_done),    32'h2A);
    check_output("st_bf",          32'(rd_bus.busy_flag), 32'h0);
    check_output("st_ac",          32'(rd_bus.addr_cnt), 32'h2A);
    check_output("st_post_rnw",    32'(post_rnw),        32'h0);
    check_output("st_post_ready",  32'(post_ready),      32'h1);
    check_output("st_rs_bad",      32'(rs_bad),          32'd0);
    check_output("st_stable",      32'(stable_bad),      32'd0);

    $display("[TB] data read with poll requested");
    apply_stimulus(1'b1, 1'b1, 8'h41, 8'h41, 1, -1, 2);
    check_output("dr_rs_bad",   32'(rs_bad),           32'd0);
    check_output("dr_pulses",   32'(pulses),           32'd1);
    check_output("dr_done_cyc", 32'(done_cyc),         32'd56);
    check_output("dr_rd_data",  32'(data_at_done),     32'h41);
    check_output("dr_bf",       32'(rd_bus.busy_flag), 32'h0);
    check_output("dr_ac",       32'(rd_bus.addr_cnt),  32'h2A);
    check_output("dr_stable",   32'(stable_bad),       32'd0);

    $display("[TB] data read of a byte with bit 7 set");
    apply_stimulus(1'b1, 1'b1, 8'hC1, 8'hC1, 1, -1, 2);
    check_output("dr7_pulses",   32'(pulses),           32'd1);
    check_output("dr7_done_cyc", 32'(done_cyc),         32'd56);
    check_output("dr7_rd_data",  32'(data_at_done),     32'hC1);
    check_output("dr7_bf",       32'(rd_bus.busy_flag), 32'h0);
    check_output("dr7_ac",       32'(rd_bus.addr_cnt),  32'h2A);

    $display("[TB] poll until busy clears");
    apply_stimulus(1'b0, 1'b1, 8'h85, 8'h06, 3, -1, 2);
    check_output("ps_pulses",   32'(pulses),           32'd4);
    check_output("ps_done_cyc", 32'(done_cyc),         32'd221);
    check_output("ps_timeout",  32'(timeout_at_done),  32'h0);
    check_output("ps_rd_data",  32'(data_at_done),     32'h06);
    check_output("ps_bf",       32'(rd_bus.busy_flag), 32'h0);
    check_output("ps_ac",       32'(rd_bus.addr_cnt),  32'h06);
    check_output("ps_stable",   32'(stable_bad),       32'd0);

    $display("[TB] poll timeout");
    apply_stimulus(1'b0, 1'b1, 8'hFF, 8'hFF, 100, -1, 2);
    check_output("pt_pulses",   32'(pulses),           32'd4);
    check_output("pt_done_cyc", 32'(done_cyc),         32'd221);
    check_output("pt_timeout",  32'(timeout_at_done),  32'h1);
    check_output("pt_rd_data",  32'(data_at_done),     32'hFF);
    check_output("pt_bf",       32'(rd_bus.busy_flag), 32'h1);
    check_output("pt_ac",       32'(rd_bus.addr_cnt),  32'h7F);
    check_output("pt_stable",   32'(stable_bad),       32'd0);

    $display("[TB] second request during E low is ignored");
    apply_stimulus(1'b0, 1'b0, 8'h13, 8'h13, 1, 40, 100);
    check_output("ig_done_count", 32'(done_count),      32'd1);
    check_output("ig_done_cyc",   32'(done_cyc),        32'd56);
    check_output("ig_rd_data",    32'(data_at_done),    32'h13);
    check_output("ig_timeout",    32'(timeout_at_done), 32'h0);

    $display("[TB] reset abort during E high");
    rd_bus.rd_rs  = 1'b0;
    rd_bus.poll   = 1'b0;
    rd_bus.rd_req = 1'b1;
    lcd_data_in   = 8'h55;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      rd_bus.rd_req = 1'b0;
    end
    check_output("ab_e_before", 32'(lcd_e), 32'h1);
    reset = 1'b0;
    #1;
    check_output("ab_e_drop",   32'(lcd_e),        32'h0);
    check_output("ab_bus_own",  32'(bus_own),      32'h0);
    check_output("ab_ready",    32'(rd_bus.ready), 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rd_bus.done) done_seen++;
    end
    check_output("ab_no_done",   32'(done_seen),        32'd0);
    check_output("ab_ready_end", 32'(rd_bus.ready),     32'h1);
    check_output("ab_rd_data",   32'(rd_bus.rd_data),   32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Read-side companion to the team's HD44780 LCD write controller.
- Performs LCD bus read cycles with R_nW=1: a status read (RS=0) returns the busy flag and address counter; a data read (RS=1) returns the DDRAM/CGRAM byte.
- Optional poll mode repeats status reads until the busy flag clears, with a bounded retry count.
- Sits beside the LCD writer under the LCD/keypad top. The top-level arbiter hands it the shared E/RS/R_nW pins while bus_own=1.

Parameters:
- T_AS, 4: clk cycles RS/R_nW are stable before E rises (setup).
- T_EH, 25: clk cycles E is held high. Data is sampled on the last of these cycles.
- T_EL, 25: clk cycles E is held low after the pulse, with RS/R_nW held (hold time plus cycle-time recovery).
- MAX_POLLS, 1023: maximum status reads in one poll transaction before timeout.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_req  input  1  start request; sampled only while ready=1.
- rd_rs  input  1  latched at accept. 0 = status read, 1 = data read.
- poll  input  1  latched at accept. 1 = repeat status reads until BF=0. Ignored when rd_rs=1.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when the transaction ends.
- timeout  output  1  one-cycle pulse coincident with done when a poll exhausts MAX_POLLS.
- rd_data  output  8  byte from the final read.
- busy_flag  output  1  BF (bit 7) from the last status read.
- addr_cnt  output  7  AC (bits 6:0) from the last status read.
- lcd_data_in  input  8  LCD DB7..DB0 input path; the top keeps the pad tristated while bus_own=1.
- bus_own  output  1  high from SETUP entry through the E_LOW/CHECK of the last read.
- lcd_e  output  1  LCD enable.
- lcd_rs  output  1  LCD register select.
- lcd_rnw  output  1  LCD R_nW.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE immediately.
  - lcd_e=0, lcd_rs=0, lcd_rnw=0, bus_own=0, done=0, timeout=0.
  - rd_data=8'h00, busy_flag=0, addr_cnt=7'h00, ready=1, poll counter=0.
  - Reset mid-transaction aborts the transaction: no done pulse, and E drops without waiting for a clock edge.
- States: IDLE → SETUP → E_HIGH → E_LOW → CHECK → DONE → IDLE.
- IDLE:
  - ready=1.
  - rd_req=1 latches rd_rs and poll (poll is forced to 0 if rd_rs=1), clears the poll counter and moves to SETUP.
  - rd_req while not in IDLE is ignored; there is no queueing.
- SETUP: T_AS cycles. lcd_rnw=1, lcd_rs=latched rs, bus_own=1, lcd_e=0.
- E_HIGH:
  - T_EH cycles with lcd_e=1.
  - lcd_data_in is registered into an internal capture register on the final E_HIGH cycle.
  - The poll counter increments once per E pulse.
- E_LOW: T_EL cycles. lcd_e=0; RS and R_nW are held.
- CHECK: 1 cycle.
  - If poll=1, captured bit 7=1 and count<MAX_POLLS: go to SETUP for another read.
  - If poll=1, bit 7=1 and count=MAX_POLLS: go to DONE with timeout.
  - Otherwise: go to DONE.
- DONE: 1 cycle.
  - done=1; timeout=1 if flagged.
  - rd_data takes the capture register value in the same cycle.
  - If rs=0, busy_flag and addr_cnt update from it as well. On data reads they hold.
  - lcd_rnw=0, lcd_rs=0, bus_own=0.
  - Next cycle is IDLE.
- Latency:
  - Request high in cycle 0 → done in cycle T_AS+T_EH+T_EL+2 (56 with defaults).
  - Each extra poll iteration adds T_AS+T_EH+T_EL+1 cycles (55).
- Between transactions, all outputs other than ready/done/timeout hold their values.
- Poll counter width is clog2(MAX_POLLS+1). There is no wrap-around: the timeout fires at exactly MAX_POLLS reads.
- lcd_e is never high outside E_HIGH. R_nW and RS never change while lcd_e=1.

Test Plan:
- Reset check: hold reset=0 → lcd_e=0, lcd_rnw=0, bus_own=0, ready=1, rd_data=00.
- Reset release: after reset=1, with no rd_req for 100 cycles, no output changes.
- Single status read: rd_req=1, rd_rs=0, poll=0 in cycle 0, lcd_data_in=8'h2A.
  - Required: lcd_rnw=1 from cycle 1, lcd_e=1 in cycles 5-29, done in cycle 56.
  - Required: rd_data=2A, busy_flag=0, addr_cnt=2A, lcd_rnw=0 after done.
- Data read: rd_rs=1, poll=1, lcd_data_in=8'h41.
  - Required: lcd_rs=1 throughout, exactly one E pulse, done in cycle 56.
  - Required: rd_data=41, busy_flag/addr_cnt unchanged from the previous test.
- Poll success: lcd_data_in=8'h85 for the first 3 E pulses, then 8'h06.
  - Required: 4 E pulses, done in cycle 221, timeout=0, busy_flag=0, addr_cnt=06.
- Poll timeout: MAX_POLLS=4, lcd_data_in=8'hFF.
  - Required: exactly 4 E pulses, then done=timeout=1 in the same cycle (221).
  - Required: busy_flag=1, addr_cnt=7F.
- Abort and ignored request: reset=0 during cycle 15 (E_HIGH).
  - Required: lcd_e=0 before the next clk edge, no done, ready=1 after release.
  - Separately: a second rd_req pulse during E_LOW is ignored, giving exactly one done.
